// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline.
//   NOP_INSTR        : encoding presented to IF/ID for a bubble (sll $0,$0,0)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : instruction-fetch controller states
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,  // request may go out this cycle
        S_WAIT  = 2'd1,  // request outstanding, response wanted
        S_HOLD  = 2'd2,  // instruction buffered, waiting for ID to take it
        S_DROP  = 2'd3   // request outstanding but redirected: response is stale
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage controller. Owns the PC, keeps at most one request
// to instruction memory in flight, buffers the returned word and presents
// {pc_plus4, instr} to the IF/ID register. Redirects discard any stale fetch.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   id_ready          : IF/ID write enable; buffered word consumed when
//                       out_valid && id_ready at a clock edge
//   redirect          : taken branch/jump this cycle
//   redirect_pc[31:0] : target address (bits [1:0] forced to 00)
//   imem_req          : one-cycle fetch request pulse
//   imem_addr[31:0]   : word address, valid with imem_req
//   imem_rvalid       : response strobe, once per request
//   imem_rdata[31:0]  : instruction word, valid with imem_rvalid
//   out_valid         : buffered instruction present
//   pc_plus4_out      : PC+4 of buffered instruction, 0 when !out_valid
//   instr_out         : buffered instruction, NOP when !out_valid
// -----------------------------------------------------------------------------
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_buf_q, instr_buf_d;
    logic [31:0]  target_pc;

    // Masking (rather than slicing) keeps every input bit referenced.
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ISSUE;
            pc_q        <= RESET_PC;
            instr_buf_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_buf_d = instr_buf_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;

        case (state_q)
            S_ISSUE: begin
                // The only input-to-output path: a redirect suppresses the
                // request so no fetch of the wrong-path address ever starts.
                imem_req = !redirect;
                if (redirect) begin
                    pc_d = target_pc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = target_pc;
                    // A response arriving this same cycle is the stale one,
                    // so nothing remains outstanding.
                    state_d = imem_rvalid ? S_ISSUE : S_DROP;
                end else if (imem_rvalid) begin
                    instr_buf_d = imem_rdata;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    instr_buf_d = NOP_INSTR;
                    state_d     = S_ISSUE;
                end else if (id_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_ISSUE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    assign out_valid    = (state_q == S_HOLD);
    assign instr_out    = out_valid ? instr_buf_q : NOP_INSTR;
    assign pc_plus4_out = out_valid ? (pc_q + 32'd4) : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit; the bench plays instruction memory by
// driving imem_rvalid/imem_rdata by hand with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;

    int checks_q = 0;
    int errors_q = 0;

    localparam logic [31:0] TB_RESET_PC = 32'h0040_0000;

    if_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_ready     (id_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .pc_plus4_out (pc_plus4_out),
        .instr_out    (instr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; single-cycle pulses drop.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Full fetch with k=1 and id_ready=1, starting in the issue cycle.
    task automatic fetch_k1(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] pc4);
        id_ready = 1'b1;
        settle();
        check({tag, ".req"},  {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".v0"},   {31'd0, out_valid}, 32'd0);
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        settle();
        check({tag, ".wreq"}, {31'd0, imem_req}, 32'd0);
        next_cycle();
        settle();
        check({tag, ".v1"},    {31'd0, out_valid}, 32'd1);
        check({tag, ".instr"}, instr_out, data);
        check({tag, ".pc4"},   pc_plus4_out, pc4);
        check({tag, ".hreq"},  {31'd0, imem_req}, 32'd0);
        next_cycle();
    endtask

    initial begin
        // Reset state while rst is held
        #2;
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.instr", instr_out, 32'd0);
        check("rst.pc4",   pc_plus4_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back fetches, one per 3 cycles
        fetch_k1("seq0", 32'h0040_0000, 32'h2008_0001, 32'h0040_0004);
        fetch_k1("seq1", 32'h0040_0004, 32'h2009_0002, 32'h0040_0008);
        fetch_k1("seq2", 32'h0040_0008, 32'h012A_4020, 32'h0040_000C);

        // Back-pressure: 5 cycles of id_ready=0 in HOLD
        id_ready = 1'b0;
        settle();
        check("stall.req",  {31'd0, imem_req}, 32'd1);
        check("stall.addr", imem_addr, 32'h0040_000C);
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C08_0010;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("stall%0d.v", i),     {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d.instr", i), instr_out, 32'h8C08_0010);
            check($sformatf("stall%0d.pc4", i),   pc_plus4_out, 32'h0040_0010);
            check($sformatf("stall%0d.req", i),   {31'd0, imem_req}, 32'd0);
            next_cycle();
        end
        id_ready = 1'b1;
        settle();
        check("release.v", {31'd0, out_valid}, 32'd1);
        next_cycle();
        settle();
        check("release.v0",   {31'd0, out_valid}, 32'd0);
        check("release.req",  {31'd0, imem_req}, 32'd1);
        check("release.addr", imem_addr, 32'h0040_0010);

        // Redirect in WAIT, stale response two cycles later
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        settle();
        next_cycle();
        settle();
        check("drop.v",   {31'd0, out_valid}, 32'd0);
        check("drop.req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        settle();
        check("drop.req2",  {31'd0, imem_req}, 32'd0);
        check("drop.instr", instr_out, 32'd0);
        next_cycle();
        fetch_k1("tgt100", 32'h0000_0100, 32'h0000_0020, 32'h0000_0104);

        // Redirect coincident with response in WAIT
        settle();
        check("coin.addr0", imem_addr, 32'h0000_0104);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        settle();
        next_cycle();
        settle();
        check("coin.v",    {31'd0, out_valid}, 32'd0);
        check("coin.req",  {31'd0, imem_req}, 32'd1);
        check("coin.addr", imem_addr, 32'h0000_0200);

        // Redirect in ISSUE: request suppressed this cycle
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        settle();
        check("iss.req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        settle();
        check("iss.req1", {31'd0, imem_req}, 32'd1);
        check("iss.addr", imem_addr, 32'h0000_0300);
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        next_cycle();

        // Redirect in HOLD beats id_ready
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check("hold.pc4", pc_plus4_out, 32'h0000_0304);
        next_cycle();
        settle();
        check("hold.v0", {31'd0, out_valid}, 32'd0);

        // PC wrap-around
        fetch_k1("wrap", 32'hFFFF_FFFC, 32'h3333_4444, 32'h0000_0000);
        settle();
        check("wrap.addr", imem_addr, 32'h0000_0000);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        settle();
        check("mask.req0", {31'd0, imem_req}, 32'd0);
        next_cycle();
        settle();
        check("mask.req",  {31'd0, imem_req}, 32'd1);
        check("mask.addr", imem_addr, 32'h0000_0100);

        // Reset asserted during HOLD
        id_ready = 1'b0;
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_6666;
        next_cycle();
        settle();
        check("rh.v1", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        settle();
        check("rh.v",     {31'd0, out_valid}, 32'd0);
        check("rh.instr", instr_out, 32'd0);
        check("rh.pc4",   pc_plus4_out, 32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check("rh.req",  {31'd0, imem_req}, 32'd1);
        check("rh.addr", imem_addr, TB_RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
        $finish;
    end

endmodule
